// File: rtl/rv64i_io_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv64i_io_console_if
//  Brief    : Core load/store bus plus console output stream for the console port.
//  Revision : 1.0 - initial release
// ============================================================================
interface rv64i_io_console_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] io_out_addr;
    logic [XLEN-1:0] mem_out;
    logic            memory_we;
    logic [XLEN-1:0] io_in_addr;
    logic            memory_re;
    logic [XLEN-1:0] mem_in;
    logic            mem_ready;
    logic [XLEN-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;

    // master = core plus downstream sink; slave = the console port itself
    modport master (
        output io_out_addr, mem_out, memory_we, io_in_addr, memory_re, tx_ready,
        input  mem_in, mem_ready, tx_data, tx_valid
    );

    modport slave (
        input  io_out_addr, mem_out, memory_we, io_in_addr, memory_re, tx_ready,
        output mem_in, mem_ready, tx_data, tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/rv64i_io_console.sv
`default_nettype none
// ============================================================================
//  Module   : rv64i_io_console
//  Brief    : Store-captured console FIFO with core back-pressure and status loads.
//  Revision : 1.0 - initial release
// ============================================================================
module rv64i_io_console #(
    parameter int              XLEN        = 64,
    parameter int              DEPTH       = 8,
    parameter logic [XLEN-1:0] DATA_ADDR   = 64'h0,
    parameter logic [XLEN-1:0] STATUS_ADDR = 64'h8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    rv64i_io_console_if.slave         bus,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WSTALL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_we_q;
    logic                r_re_q;
    logic [XLEN-1:0]     r_stall_data;
    logic [XLEN-1:0]     r_mem_in;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [XLEN-1:0]     r_fifo [DEPTH];

    logic                w_store_ev;
    logic                w_load_ev;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [XLEN-1:0]     w_push_data;
    logic                w_latch;
    logic                w_mem_ready;
    logic [XLEN-1:0]     w_status;

    // A level held across cycles is a single request: act on the rising edge only
    assign w_store_ev = bus.memory_we & ~r_we_q;
    assign w_load_ev  = bus.memory_re & ~r_re_q;
    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & bus.tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = bus.mem_out;
        w_latch     = 1'b0;
        w_mem_ready = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_store_ev && (bus.io_out_addr == DATA_ADDR)) begin
                    // A simultaneous pop frees the slot this same cycle
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_mem_ready = 1'b0;
                        w_state_nxt = ST_WSTALL;
                    end
                end
            end
            ST_WSTALL: begin
                w_mem_ready = 1'b0;
                if (w_pop) begin
                    w_push      = 1'b1;
                    w_push_data = r_stall_data;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_status                = '0;
        w_status[0]             = w_empty;
        w_status[1]             = w_full;
        w_status[2]             = (r_state == ST_WSTALL);
        w_status[8 +: c_cnt_w]  = r_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_we_q       <= 1'b0;
            r_re_q       <= 1'b0;
            r_stall_data <= '0;
            r_mem_in     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we_q  <= bus.memory_we;
            r_re_q  <= bus.memory_re;
            if (w_latch) begin
                r_stall_data <= bus.mem_out;
            end
            if (w_load_ev) begin
                r_mem_in <= (bus.io_in_addr == STATUS_ADDR) ? w_status : '0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head read is zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
        end
    end

    assign bus.mem_in    = r_mem_in;
    assign bus.mem_ready = w_mem_ready;
    assign bus.tx_data   = r_fifo[r_rd_ptr];
    assign bus.tx_valid  = ~w_empty;
    assign fifo_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rv64i_io_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv64i_io_console
//  Brief    : Directed table, corner sequences and random traffic vs a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv64i_io_console;

    localparam int          XLEN        = 64;
    localparam int          DEPTH       = 8;
    localparam logic [63:0] DATA_ADDR   = 64'h0;
    localparam logic [63:0] STATUS_ADDR = 64'h8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    rv64i_io_console_if #(.XLEN(XLEN)) bus ();

    rv64i_io_console #(
        .XLEN(XLEN), .DEPTH(DEPTH), .DATA_ADDR(DATA_ADDR), .STATUS_ADDR(STATUS_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .fifo_count(fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue plus a single parked word
    logic [63:0] mq[$];
    bit          m_stall;
    logic [63:0] m_stall_word;
    bit          m_we_q;
    bit          m_re_q;
    logic [63:0] m_mem_in;
    logic        last_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_stall      = 1'b0;
        m_stall_word = '0;
        m_we_q       = 1'b0;
        m_re_q       = 1'b0;
        m_mem_in     = '0;
    endfunction

    function automatic logic [63:0] model_status();
        logic [63:0] s;
        s       = '0;
        s[0]    = (mq.size() == 0);
        s[1]    = (mq.size() == DEPTH);
        s[2]    = m_stall;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    // One clock cycle: drive, check combinational ready, clock, check state
    task automatic drive_cycle(input logic we, input logic [63:0] oaddr, input logic [63:0] odata,
                               input logic re, input logic [63:0] iaddr, input logic txr);
        bit          store_ev, load_ev, pop, full, exp_ready;
        logic [63:0] status;
        bus.memory_we   = we;
        bus.io_out_addr = oaddr;
        bus.mem_out     = odata;
        bus.memory_re   = re;
        bus.io_in_addr  = iaddr;
        bus.tx_ready    = txr;
        #1;
        store_ev  = we && !m_we_q;
        load_ev   = re && !m_re_q;
        full      = (mq.size() == DEPTH);
        pop       = (mq.size() != 0) && txr;
        exp_ready = !m_stall && !(store_ev && oaddr == DATA_ADDR && full && !pop);
        last_ready = bus.mem_ready;
        check("mem_ready", 64'(bus.mem_ready), 64'(exp_ready));
        status = model_status();
        @(posedge clk);
        if (load_ev) m_mem_in = (iaddr == STATUS_ADDR) ? status : 64'h0;
        if (pop) mq.delete(0);
        if (m_stall) begin
            if (pop) begin
                mq.push_back(m_stall_word);
                m_stall = 1'b0;
            end
        end else if (store_ev && oaddr == DATA_ADDR) begin
            if (!full || pop) mq.push_back(odata);
            else begin
                m_stall      = 1'b1;
                m_stall_word = odata;
            end
        end
        m_we_q = we;
        m_re_q = re;
        #1;
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        check("tx_valid", 64'(bus.tx_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) check("tx_data", bus.tx_data, mq[0]);
        check("mem_in", bus.mem_in, m_mem_in);
    endtask

    task automatic store_word(input logic [63:0] d);
        drive_cycle(1'b1, DATA_ADDR, d, 1'b0, 64'h0, 1'b0);
        drive_cycle(1'b0, DATA_ADDR, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && fifo_count != 0; k++)
            drive_cycle(1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1);
        check("drain_empty", 64'(fifo_count), 64'h0);
    endtask

    typedef struct {
        logic        we;
        logic [63:0] oaddr;
        logic [63:0] odata;
        logic        re;
        logic [63:0] iaddr;
        logic        txr;
        logic        exp_ready;
        int          exp_count;
        logic [63:0] exp_head;
        logic [63:0] exp_mem_in;
    } vec_t;

    function automatic vec_t mk(logic we, logic [63:0] oaddr, logic [63:0] odata, logic re,
                                logic [63:0] iaddr, logic txr, logic rdy, int cnt,
                                logic [63:0] head, logic [63:0] mi);
        vec_t v;
        v.we = we; v.oaddr = oaddr; v.odata = odata; v.re = re; v.iaddr = iaddr; v.txr = txr;
        v.exp_ready = rdy; v.exp_count = cnt; v.exp_head = head; v.exp_mem_in = mi;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[14];
        logic [63:0] wa, wb, wc, wx;
        logic [63:0] w[9];

        wa = 64'h0F0F07F00F0F07F0;
        wb = 64'h2222_3333_4444_5555;
        wc = 64'hC0DE_0000_FFFF_0001;
        wx = 64'hDEAD_BEEF_DEAD_BEEF;

        vecs[0]  = mk(1, 64'h0,  wa, 0, 64'h0,  0, 1, 1, wa, 64'h0);
        vecs[1]  = mk(1, 64'h0,  wa, 0, 64'h0,  0, 1, 1, wa, 64'h0);
        vecs[2]  = mk(1, 64'h0,  wa, 0, 64'h0,  0, 1, 1, wa, 64'h0);
        vecs[3]  = mk(1, 64'h0,  wa, 0, 64'h0,  0, 1, 1, wa, 64'h0);
        vecs[4]  = mk(0, 64'h0,  wa, 0, 64'h0,  0, 1, 1, wa, 64'h0);
        vecs[5]  = mk(1, 64'h0,  wb, 0, 64'h0,  0, 1, 2, wa, 64'h0);
        vecs[6]  = mk(0, 64'h0,  wb, 0, 64'h0,  0, 1, 2, wa, 64'h0);
        vecs[7]  = mk(1, 64'h0,  wc, 0, 64'h0,  0, 1, 3, wa, 64'h0);
        vecs[8]  = mk(0, 64'h0,  wc, 1, 64'h8,  0, 1, 3, wa, 64'h300);
        vecs[9]  = mk(0, 64'h0,  wc, 0, 64'h8,  0, 1, 3, wa, 64'h300);
        vecs[10] = mk(0, 64'h0,  wc, 1, 64'h10, 0, 1, 3, wa, 64'h0);
        vecs[11] = mk(1, 64'h20, wx, 0, 64'h0,  0, 1, 3, wa, 64'h0);
        vecs[12] = mk(0, 64'h0,  wx, 0, 64'h0,  1, 1, 2, wb, 64'h0);
        vecs[13] = mk(0, 64'h0,  wx, 1, 64'h8,  0, 1, 2, wb, 64'h200);

        bus.memory_we = 0; bus.io_out_addr = '0; bus.mem_out = '0;
        bus.memory_re = 0; bus.io_in_addr = '0; bus.tx_ready = 0;
        model_reset();
        #2;
        check("rst_count", 64'(fifo_count), 64'h0);
        check("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'h1);
        check("rst_mem_in", bus.mem_in, 64'h0);
        check("rst_tx_data", bus.tx_data, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].we, vecs[i].oaddr, vecs[i].odata, vecs[i].re,
                        vecs[i].iaddr, vecs[i].txr);
            check($sformatf("vec%0d_ready", i), 64'(last_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_head", i), bus.tx_data, vecs[i].exp_head);
            check($sformatf("vec%0d_mem_in", i), bus.mem_in, vecs[i].exp_mem_in);
        end
        drain();

        // Fill, stall on the ninth word, release with a single pop
        for (int i = 0; i < 9; i++) w[i] = {32'h5A5A_0000 + 32'(i), $urandom()};
        for (int i = 0; i < 8; i++) store_word(w[i]);
        check("full_count", 64'(fifo_count), 64'h8);
        drive_cycle(1'b1, DATA_ADDR, w[8], 1'b0, 64'h0, 1'b0);
        check("stall_ready_low", 64'(last_ready), 64'h0);
        drive_cycle(1'b0, DATA_ADDR, 64'h0, 1'b1, STATUS_ADDR, 1'b0);
        check("stall_ready_held", 64'(last_ready), 64'h0);
        check("stall_status", bus.mem_in, 64'h806);
        drive_cycle(1'b0, DATA_ADDR, 64'h0, 1'b0, 64'h0, 1'b1);
        check("release_pop_ready", 64'(last_ready), 64'h0);
        check("release_count", 64'(fifo_count), 64'h8);
        check("release_head", bus.tx_data, w[1]);
        drive_cycle(1'b0, DATA_ADDR, 64'h0, 1'b0, 64'h0, 1'b0);
        check("release_ready_back", 64'(last_ready), 64'h1);
        drain();

        // Full FIFO, store coincides with a pop: no stall
        for (int i = 0; i < 8; i++) store_word(w[i]);
        drive_cycle(1'b1, DATA_ADDR, w[8], 1'b0, 64'h0, 1'b1);
        check("fullpop_ready", 64'(last_ready), 64'h1);
        check("fullpop_count", 64'(fifo_count), 64'h8);
        check("fullpop_head", bus.tx_data, w[1]);
        drain();

        // Reset while stalled drops the parked word
        for (int i = 0; i < 8; i++) store_word(w[i]);
        drive_cycle(1'b1, DATA_ADDR, w[8], 1'b0, 64'h0, 1'b0);
        check("pre_reset_stall", 64'(last_ready), 64'h0);
        bus.memory_we = 0; bus.memory_re = 0; bus.tx_ready = 0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_count", 64'(fifo_count), 64'h0);
        check("midrst_tx_valid", 64'(bus.tx_valid), 64'h0);
        check("midrst_mem_ready", 64'(bus.mem_ready), 64'h1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, DATA_ADDR, 64'h0, 1'b0, 64'h0, 1'b1);
            check("post_rst_no_word", 64'(bus.tx_valid), 64'h0);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            drive_cycle(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 64'h20 : DATA_ADDR,
                        {$urandom(), $urandom()},
                        1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0) ? 64'h10 : STATUS_ADDR,
                        ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
